// File: rtl/score_writer.sv
// Turns note/rest duration events into linear score words in a single-port RAM, with bar lines per measure.
// Build option TIE_SPLIT_EN: an event that overruns the measure is tied and its remainder carries over.
module score_writer #(
   parameter int MEM_DEPTH       = 1024,
   parameter int MEASURE_EIGHTHS = 8,
   parameter int FIFO_DEPTH      = 4,
   localparam int ADDR_W         = $clog2(MEM_DEPTH)
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   input  logic              stop_in,
   input  logic              event_valid_in,
   input  logic [5:0]        event_tone_in,
   input  logic [7:0]        event_dur_in,
   output logic              wr_en_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [10:0]       wr_data_out,
   output logic              busy_out,
   output logic              done_out,
   output logic [ADDR_W-1:0] word_count_out,
   output logic              overflow_out
);

   // state  | meaning
   // IDLE   | waiting for start_in
   // RECORD | pop FIFO, write event word
   // BAR    | write one bar word, FIFO holds
   // FLUSH  | drain FIFO, then write END
   // DONE   | score complete, start_in restarts
   typedef enum logic [2:0] {S_IDLE, S_RECORD, S_BAR, S_FLUSH, S_DONE} state_t;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]    CNT_ONE   = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [4:0]        M5        = 5'(MEASURE_EIGHTHS);
   localparam logic [10:0]       WORD_BAR  = 11'h400;
   localparam logic [10:0]       WORD_END  = 11'h600;

   state_t            state;
   logic [3:0]        fill;
   logic              flush_pend;

   logic [8:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [PTR_W:0]    fifo_cnt;

   logic              dur_rest, onehot;
   logic [3:0]        nib;
   logic [1:0]        dur_code;
   logic              fifo_empty, fifo_full;
   logic              start_acc, recording, drain, at_last;
   logic              push_req, push, pop, drop, mem_hit, fifo_clr;
   logic [ADDR_W-1:0] addr_now;
   logic [8:0]        head;
   logic [4:0]        sum;
   logic              tie_bit;
   logic [3:0]        fill_over;

   assign dur_rest   = |event_dur_in[7:4];
   assign nib        = dur_rest ? event_dur_in[7:4] : event_dur_in[3:0];
   assign dur_code   = {nib[3] | nib[2], nib[3] | nib[1]};
   assign onehot     = (event_dur_in != 8'd0) && ((event_dur_in & (event_dur_in - 8'd1)) == 8'd0);

   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_FULL);
   assign start_acc  = start_in && (state == S_IDLE || state == S_DONE);
   // Intake stays open during the one-cycle bar so a steady event stream is not lost.
   assign recording  = (state == S_RECORD) || (state == S_BAR);
   assign drain      = (state == S_RECORD && !stop_in) || (state == S_FLUSH);
   // Pointer saturates at the END slot so word_count never wraps past the last address.
   assign addr_now   = (wr_en_out && wr_addr_out != LAST) ? wr_addr_out + ADDR_ONE : wr_addr_out;
   assign at_last    = (addr_now == LAST);
   assign pop        = drain && !fifo_empty && !at_last;
   assign mem_hit    = (drain && !fifo_empty && at_last) || (state == S_BAR && at_last);
   assign fifo_clr   = start_acc || mem_hit;
   assign push_req   = recording && event_valid_in && onehot;
   assign push       = push_req && (!fifo_full || pop);
   assign drop       = push_req && fifo_full && !pop;

   assign head       = fifo_mem[rd_ptr];
   assign sum        = {1'b0, fill} + (5'd1 << head[7:6]);

`ifdef TIE_SPLIT_EN
   logic [4:0] diff;
   assign diff      = sum - M5;
   assign tie_bit   = (sum > M5);
   // A remainder longer than a whole measure is clamped to just under one measure.
   assign fill_over = (diff >= M5) ? M5[3:0] - 4'd1 : diff[3:0];
`else
   assign tie_bit   = 1'b0;
   assign fill_over = 4'd0;
`endif

   assign word_count_out = wr_addr_out;

   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[wr_ptr] <= {dur_rest, dur_code, event_tone_in};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || fifo_clr) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= S_IDLE;
         fill         <= '0;
         flush_pend   <= 1'b0;
         wr_en_out    <= 1'b0;
         wr_addr_out  <= '0;
         wr_data_out  <= '0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
         overflow_out <= 1'b0;
      end else begin
         wr_en_out   <= 1'b0;
         wr_addr_out <= addr_now;
         if (drop) overflow_out <= 1'b1;
         case (state)
            S_IDLE, S_DONE: begin
               if (start_acc) begin
                  state        <= S_RECORD;
                  busy_out     <= 1'b1;
                  done_out     <= 1'b0;
                  wr_addr_out  <= '0;
                  fill         <= '0;
                  flush_pend   <= 1'b0;
                  overflow_out <= 1'b0;
               end else begin
                  done_out <= (state == S_DONE);
               end
            end
            S_RECORD, S_FLUSH: begin
               if (state == S_RECORD && stop_in) begin
                  state <= S_FLUSH;
               end else if (mem_hit) begin
                  wr_en_out    <= 1'b1;
                  wr_data_out  <= WORD_END;
                  overflow_out <= 1'b1;
                  busy_out     <= 1'b0;
                  state        <= S_DONE;
               end else if (pop) begin
                  wr_en_out   <= 1'b1;
                  wr_data_out <= {1'b0, head[8], head[7:6], head[5:0], (sum >= M5) && tie_bit};
                  if (sum < M5) begin
                     fill <= sum[3:0];
                  end else begin
                     fill       <= fill_over;
                     flush_pend <= (state == S_FLUSH);
                     state      <= S_BAR;
                  end
               end else if (state == S_FLUSH) begin
                  wr_en_out   <= 1'b1;
                  wr_data_out <= WORD_END;
                  busy_out    <= 1'b0;
                  state       <= S_DONE;
               end
            end
            S_BAR: begin
               wr_en_out <= 1'b1;
               if (mem_hit) begin
                  wr_data_out  <= WORD_END;
                  overflow_out <= 1'b1;
                  busy_out     <= 1'b0;
                  state        <= S_DONE;
               end else begin
                  wr_data_out <= WORD_BAR;
                  state       <= (stop_in || flush_pend) ? S_FLUSH : S_RECORD;
               end
            end
            default: begin
               state    <= S_IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_score_writer.sv
// Directed bench for score_writer: default-size instance plus an 8-word instance for the memory limit.
// Expectations for the overflowing-event tie follow the TIE_SPLIT_EN build option.
module tb_score_writer;

   logic        clk_in = 1'b0;
   logic        rst_in, start_in, stop_in, event_valid_in;
   logic [5:0]  event_tone_in;
   logic [7:0]  event_dur_in;

   logic        wr_en, busy, done, ovf;
   logic [9:0]  wr_addr, count;
   logic [10:0] wr_data;
   logic        s_wr_en, s_busy, s_done, s_ovf;
   logic [2:0]  s_wr_addr, s_count;
   logic [10:0] s_wr_data;

   logic [9:0]  log_addr[$];
   logic [10:0] log_data[$];
   logic [2:0]  s_log_addr[$];
   logic [10:0] s_log_data[$];

   int checks = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   score_writer dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
      .event_valid_in(event_valid_in), .event_tone_in(event_tone_in), .event_dur_in(event_dur_in),
      .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data), .busy_out(busy),
      .done_out(done), .word_count_out(count), .overflow_out(ovf)
   );

   score_writer #(.MEM_DEPTH(8)) dut_small (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
      .event_valid_in(event_valid_in), .event_tone_in(event_tone_in), .event_dur_in(event_dur_in),
      .wr_en_out(s_wr_en), .wr_addr_out(s_wr_addr), .wr_data_out(s_wr_data), .busy_out(s_busy),
      .done_out(s_done), .word_count_out(s_count), .overflow_out(s_ovf)
   );

   always @(negedge clk_in) begin
      if (wr_en) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      if (s_wr_en) begin
         s_log_addr.push_back(s_wr_addr);
         s_log_data.push_back(s_wr_data);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic clear_logs();
      log_addr.delete();
      log_data.delete();
      s_log_addr.delete();
      s_log_data.delete();
   endtask

   task automatic send(input logic [5:0] tone, input logic [7:0] dur);
      event_valid_in = 1'b1;
      event_tone_in  = tone;
      event_dur_in   = dur;
      tick();
      event_valid_in = 1'b0;
      event_tone_in  = 6'd0;
      event_dur_in   = 8'd0;
   endtask

   task automatic pulse_start();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
   endtask

   task automatic stop_and_wait(input string name);
      int n;
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         $display("FAIL %s_done_timeout got=%b exp=1", name, done);
         failures++;
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; start_in = 1'b0; stop_in = 1'b0;
      event_valid_in = 1'b0; event_tone_in = 6'd0; event_dur_in = 8'd0;
      tick(3);
      checks++;
      if ({wr_en, busy, done, ovf} !== 4'b0000) begin
         $display("FAIL reset_flags got=%b exp=0000", {wr_en, busy, done, ovf});
         failures++;
      end
      checks++;
      if (wr_addr !== 10'd0 || count !== 10'd0) begin
         $display("FAIL reset_addr got=%0d/%0d exp=0/0", wr_addr, count);
         failures++;
      end
      checks++;
      if (wr_data !== 11'd0) begin
         $display("FAIL reset_data got=%0h exp=0", wr_data);
         failures++;
      end
      checks++;
      if ({s_wr_en, s_busy, s_done, s_ovf, s_count} !== 7'd0) begin
         $display("FAIL reset_small got=%b exp=0", {s_wr_en, s_busy, s_done, s_ovf, s_count});
         failures++;
      end
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_measure_bar();
      clear_logs();
      pulse_start();
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL bar_busy got=%b exp=1", busy);
         failures++;
      end
      send(6'd12, 8'h02);
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== 11'h098) begin
         $display("FAIL bar_latency got=%b@%0d:%0h exp=1@0:98", wr_en, wr_addr, wr_data);
         failures++;
      end
      repeat (3) send(6'd12, 8'h02);
      tick(4);
      checks++;
      if (log_data.size() != 5) begin
         $display("FAIL bar_count got=%0d exp=5", log_data.size());
         failures++;
      end
      for (int i = 0; i < 5 && i < log_data.size(); i++) begin
         checks++;
         if (log_addr[i] !== 10'(i) || log_data[i] !== ((i == 4) ? 11'h400 : 11'h098)) begin
            $display("FAIL bar_word%0d got=%0d:%0h exp=%0d:%0h", i, log_addr[i], log_data[i],
                     i, (i == 4) ? 11'h400 : 11'h098);
            failures++;
         end
      end
      checks++;
      if (count !== 10'd5) begin
         $display("FAIL bar_wordcount got=%0d exp=5", count);
         failures++;
      end
      stop_and_wait("bar");
      checks++;
      if (log_data.size() != 6 || log_data[log_data.size()-1] !== 11'h600 || count !== 10'd6) begin
         $display("FAIL bar_end got=n%0d cnt%0d exp=n6 cnt6", log_data.size(), count);
         failures++;
      end
   endtask

   task automatic test_rest_stop();
      clear_logs();
      pulse_start();
      send(6'd0, 8'h80);
      tick(3);
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      tick();
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 10'd2 || wr_data !== 11'h600 || done !== 1'b0) begin
         $display("FAIL stop_end got=%b@%0d:%0h d%b exp=1@2:600 d0", wr_en, wr_addr, wr_data, done);
         failures++;
      end
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || count !== 10'd3) begin
         $display("FAIL stop_done got=d%b b%b c%0d exp=d1 b0 c3", done, busy, count);
         failures++;
      end
      checks++;
      if (log_data.size() != 3) begin
         $display("FAIL stop_words got=%0d exp=3", log_data.size());
         failures++;
      end else begin
         checks++;
         if (log_data[0] !== 11'h380 || log_data[1] !== 11'h400 || log_addr[1] !== 10'd1) begin
            $display("FAIL stop_rest_bar got=%0h,%0h@%0d exp=380,400@1", log_data[0], log_data[1], log_addr[1]);
            failures++;
         end
      end
   endtask

   task automatic test_tie_split();
      logic [10:0] exp_d[$];
      clear_logs();
      pulse_start();
      repeat (3) send(6'd12, 8'h02);
      send(6'd5, 8'h04);
      tick(3);
      repeat (6) send(6'd1, 8'h01);
      tick(4);
      stop_and_wait("tie");
      repeat (3) exp_d.push_back(11'h098);
`ifdef TIE_SPLIT_EN
      exp_d.push_back(11'h10B);
      exp_d.push_back(11'h400);
      repeat (6) exp_d.push_back(11'h002);
      exp_d.push_back(11'h400);
`else
      exp_d.push_back(11'h10A);
      exp_d.push_back(11'h400);
      repeat (6) exp_d.push_back(11'h002);
`endif
      exp_d.push_back(11'h600);
      checks++;
      if (log_data.size() != exp_d.size()) begin
         $display("FAIL tie_count got=%0d exp=%0d", log_data.size(), exp_d.size());
         failures++;
      end
      for (int i = 0; i < exp_d.size() && i < log_data.size(); i++) begin
         checks++;
         if (log_data[i] !== exp_d[i] || log_addr[i] !== 10'(i)) begin
            $display("FAIL tie_word%0d got=%0d:%0h exp=%0d:%0h", i, log_addr[i], log_data[i], i, exp_d[i]);
            failures++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp_d[$];
      clear_logs();
      pulse_start();
      for (int k = 1; k <= 8; k++) send(6'(k), 8'h08);
      checks++;
      if (ovf !== 1'b0) begin
         $display("FAIL b2b_full_pushpop got=%b exp=0", ovf);
         failures++;
      end
      send(6'd9, 8'h08);
      checks++;
      if (ovf !== 1'b1) begin
         $display("FAIL b2b_drop got=%b exp=1", ovf);
         failures++;
      end
      tick(20);
      stop_and_wait("b2b");
      for (int k = 1; k <= 8; k++) begin
         exp_d.push_back(11'h180 | 11'(k << 1));
         exp_d.push_back(11'h400);
      end
      exp_d.push_back(11'h600);
      checks++;
      if (log_data.size() != exp_d.size()) begin
         $display("FAIL b2b_count got=%0d exp=%0d", log_data.size(), exp_d.size());
         failures++;
      end
      for (int i = 0; i < exp_d.size() && i < log_data.size(); i++) begin
         checks++;
         if (log_data[i] !== exp_d[i]) begin
            $display("FAIL b2b_word%0d got=%0h exp=%0h", i, log_data[i], exp_d[i]);
            failures++;
         end
      end
   endtask

   task automatic test_mem_limit();
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      tick(12);
      pulse_start();
      clear_logs();
      repeat (10) send(6'd3, 8'h01);
      tick(5);
      checks++;
      if (s_log_data.size() != 8) begin
         $display("FAIL mem_count got=%0d exp=8", s_log_data.size());
         failures++;
      end
      for (int i = 0; i < 8 && i < s_log_data.size(); i++) begin
         checks++;
         if (s_log_addr[i] !== 3'(i) || s_log_data[i] !== ((i == 7) ? 11'h600 : 11'h006)) begin
            $display("FAIL mem_word%0d got=%0d:%0h exp=%0d:%0h", i, s_log_addr[i], s_log_data[i],
                     i, (i == 7) ? 11'h600 : 11'h006);
            failures++;
         end
      end
      checks++;
      if ({s_done, s_ovf, s_busy} !== 3'b110) begin
         $display("FAIL mem_status got=%b exp=110", {s_done, s_ovf, s_busy});
         failures++;
      end
      stop_and_wait("mem_big");
   endtask

   task automatic test_discard_reset();
      clear_logs();
      pulse_start();
      send(6'd4, 8'h00);
      send(6'd4, 8'h03);
      send(6'd4, 8'h81);
      tick(4);
      checks++;
      if (log_data.size() != 0 || ovf !== 1'b0) begin
         $display("FAIL discard_bad got=n%0d o%b exp=n0 o0", log_data.size(), ovf);
         failures++;
      end
      send(6'd7, 8'h02);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      tick(3);
      checks++;
      if (log_data.size() != 0) begin
         $display("FAIL discard_reset_write got=%0d exp=0", log_data.size());
         failures++;
      end
      checks++;
      if ({wr_en, busy, done, ovf} !== 4'b0000 || wr_addr !== 10'd0 || wr_data !== 11'd0 || count !== 10'd0) begin
         $display("FAIL discard_reset_state got=%b a%0d d%0h c%0d exp=0000 a0 d0 c0",
                  {wr_en, busy, done, ovf}, wr_addr, wr_data, count);
         failures++;
      end
      send(6'd7, 8'h02);
      tick(4);
      checks++;
      if (log_data.size() != 0 || busy !== 1'b0) begin
         $display("FAIL discard_idle got=n%0d b%b exp=n0 b0", log_data.size(), busy);
         failures++;
      end
   endtask

   initial begin
      test_reset();
      test_measure_bar();
      test_rest_stop();
      test_tie_split();
      test_back_to_back();
      test_mem_limit();
      test_discard_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
